// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port memory between a video line fetcher (fixed-length bursts)
// and a host port (single-word reads/writes), alternating on ties and inserting a turnaround cycle.
module vga_mem_arbiter #(
  parameter int AW    = 19,
  parameter int DW    = 32,
  parameter int BURST = 16
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_done,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    HOST = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          last_vid;
  logic [AW-1:0] base;
  logic [CW-1:0] cnt;
  logic          grant_vid, grant_host, burst_last;

  // Handshakes: a requester holds *_req high until its one-cycle ack; the memory
  // completes an access on any edge where mem_req and mem_ack are both high, and
  // mem_ack is ignored while mem_req is low.
  always_comb begin
    state_n    = state;
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    burst_last = (cnt == CW'(BURST - 1));
    case (state)
      IDLE: begin
        if (vid_req && (!host_req || !last_vid)) begin
          grant_vid = 1'b1;
          state_n   = VID;
        end else if (host_req) begin
          grant_host = 1'b1;
          state_n    = HOST;
        end
      end
      VID:     if (mem_ack && burst_last) state_n = TURN;
      HOST:    if (mem_ack) state_n = TURN;
      TURN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) state <= IDLE;
    else           state <= state_n;
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      last_vid   <= 1'b0;
      base       <= '0;
      cnt        <= '0;
      vid_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
      vid_done   <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      vid_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      vid_done   <= 1'b0;
      host_ack   <= 1'b0;
      if (grant_vid) begin
        base     <= vid_addr;
        cnt      <= '0;
        last_vid <= 1'b1;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= vid_addr;
        vid_ack  <= 1'b1;
      end
      if (grant_host) begin
        last_vid  <= 1'b0;
        mem_req   <= 1'b1;
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end
      // Burst address is rebuilt from the latched base so it wraps modulo 2^AW.
      if (state == VID && mem_ack) begin
        vid_rvalid <= 1'b1;
        vid_rdata  <= mem_rdata;
        cnt        <= cnt + CW'(1);
        mem_addr   <= base + AW'(cnt) + AW'(1);
        if (burst_last) begin
          vid_done <= 1'b1;
          mem_req  <= 1'b0;
        end
      end
      if (state == HOST && mem_ack) begin
        host_ack   <= 1'b1;
        host_rdata <= mem_rdata;
        mem_req    <= 1'b0;
        mem_we     <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized request/ack traffic.
module tb_vga_mem_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 32;
  localparam int BURST = 4;

  logic          pixel_clk, pixel_rst;
  logic          vid_req, vid_ack, vid_rvalid, vid_done;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  vga_mem_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_done(vid_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // ---------------- memory responder ----------------
  int ack_mode = 1;   // 0 random, 1 always ack, 2 stall after two returned words
  int rv_seen = 0;
  int stall_left = 0;
  bit stall_done = 0;
  bit stall_active = 0;
  logic [DW-1:0] mem_store [logic [AW-1:0]];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge pixel_clk);
      if (vid_ack) rv_seen = 0;
      if (vid_rvalid) rv_seen++;
      #1;
      case (ack_mode)
        1: mem_ack = 1'b1;
        2: begin
          if (stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
          end else if (rv_seen == 2 && !stall_done) begin
            stall_done   = 1;
            stall_active = 1;
            stall_left   = 4;
            mem_ack      = 1'b0;
          end else begin
            mem_ack = 1'b1;
          end
        end
        default: mem_ack = ($urandom_range(0, 2) != 0);
      endcase
      if (mem_store.exists(mem_addr)) mem_rdata = mem_store[mem_addr];
      else                            mem_rdata = $urandom;
      if (mem_req && mem_ack && mem_we) mem_store[mem_addr] = mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  int            m_phase = 0;   // 0 idle, 1 video burst, 2 host access, 3 turnaround
  int            m_words = 0;
  logic [AW-1:0] m_base = '0;
  bit            m_last_vid = 0;
  bit            m_host_read = 0;
  logic          e_vid_ack = 0, e_vid_rvalid = 0, e_vid_done = 0, e_host_ack = 0;
  logic          e_mem_req = 0, e_mem_we = 0;
  logic [AW-1:0] e_mem_addr = '0;
  logic [DW-1:0] e_mem_wdata = '0, e_vid_rdata = '0, e_host_rdata = '0;

  always @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      m_phase = 0; m_words = 0; m_last_vid = 0;
      e_vid_ack = 0; e_vid_rvalid = 0; e_vid_done = 0; e_host_ack = 0;
      e_mem_req = 0; e_mem_we = 0;
    end else begin
      e_vid_ack = 0; e_vid_rvalid = 0; e_vid_done = 0; e_host_ack = 0;
      if (m_phase == 0) begin
        if (vid_req && (!host_req || !m_last_vid)) begin
          m_phase = 1; m_base = vid_addr; m_words = 0; m_last_vid = 1;
          e_vid_ack = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = vid_addr;
        end else if (host_req) begin
          m_phase = 2; m_last_vid = 0; m_host_read = !host_we;
          e_mem_req = 1; e_mem_we = host_we; e_mem_addr = host_addr; e_mem_wdata = host_wdata;
        end
      end else if (m_phase == 1) begin
        if (mem_ack) begin
          m_words++;
          e_vid_rvalid = 1; e_vid_rdata = mem_rdata;
          e_mem_addr = AW'((int'(m_base) + m_words) % (1 << AW));
          if (m_words == BURST) begin
            e_vid_done = 1; e_mem_req = 0; m_phase = 3;
          end
        end
      end else if (m_phase == 2) begin
        if (mem_ack) begin
          e_host_ack = 1; e_host_rdata = mem_rdata;
          e_mem_req = 0; e_mem_we = 0; m_phase = 3;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge pixel_clk) begin
    chk("vid_ack", vid_ack, e_vid_ack);
    chk("vid_rvalid", vid_rvalid, e_vid_rvalid);
    chk("vid_done", vid_done, e_vid_done);
    chk("host_ack", host_ack, e_host_ack);
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_we", mem_we, e_mem_we);
    if (e_vid_rvalid) chk("vid_rdata", vid_rdata, e_vid_rdata);
    if (e_host_ack && m_host_read) chk("host_rdata", host_rdata, e_host_rdata);
    if (e_mem_req) chk("mem_addr", mem_addr, e_mem_addr);
    if (e_mem_req && e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
  end

  // ---------------- event logs for directed checks ----------------
  logic [AW:0]   hs_log[$];
  logic [DW-1:0] hrd_log[$];
  int            grant_log[$];   // 1 = video, 2 = host
  int            done_at[$];
  int            rv_cnt = 0, vack_cnt = 0;
  logic          prev_req = 0;

  always @(negedge pixel_clk) begin
    if (mem_req && !prev_req) grant_log.push_back(vid_ack ? 1 : 2);
    prev_req = mem_req;
    if (vid_ack) vack_cnt++;
    if (vid_rvalid) rv_cnt++;
    if (vid_done) done_at.push_back(rv_cnt);
    if (host_ack) hrd_log.push_back(host_rdata);
    if (mem_req && mem_ack) hs_log.push_back({mem_we, mem_addr});
  end

  task automatic clear_logs();
    hs_log.delete(); hrd_log.delete(); grant_log.delete(); done_at.delete();
    rv_cnt = 0; vack_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic vid_request(input logic [AW-1:0] a);
    int n;
    n = 0;
    @(negedge pixel_clk); #1;
    vid_req = 1'b1; vid_addr = a;
    while (vid_ack !== 1'b1 && n < 300) begin
      @(negedge pixel_clk); #1; n++;
    end
    if (n >= 300) timeout_fail("vid_ack_wait");
    vid_req  = 1'b0;
    vid_addr = AW'($urandom);
  endtask

  task automatic host_request(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge pixel_clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    while (host_ack !== 1'b1 && n < 300) begin
      @(negedge pixel_clk); #1; n++;
    end
    if (n >= 300) timeout_fail("host_ack_wait");
    host_req   = 1'b0;
    host_we    = $urandom_range(0, 1);
    host_addr  = AW'($urandom);
    host_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge pixel_clk); #1; n++;
    end while (!(dbg_state == 2'd0 && !mem_req) && n < 500);
    if (n >= 500) timeout_fail("wait_idle");
  endtask

  logic [AW-1:0] wrap_exp [4] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
  int            n;
  int            kind;
  logic [AW-1:0] va, ha;
  logic [DW-1:0] hd;
  logic          hwe;

  // ---------------- test sequence ----------------
  initial begin
    pixel_rst = 1'b1; vid_req = 0; vid_addr = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge pixel_clk);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_vid_rdata", vid_rdata, 0);
    #1 pixel_rst = 1'b0;

    // video burst, memory always ready
    ack_mode = 1; clear_logs();
    vid_request(19'h00100);
    wait_idle();
    chk("burst_hs_count", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      chk("burst_addr", hs_log[i], {1'b0, 19'h00100 + 19'(i)});
    chk("burst_rvalid_count", rv_cnt, 4);
    chk("burst_done_count", done_at.size(), 1);
    if (done_at.size() > 0) chk("burst_done_on_4th", done_at[0], 4);
    chk("burst_vid_ack_count", vack_cnt, 1);

    // host write then read back
    clear_logs();
    host_request(1'b1, 19'h00010, 32'hDEADBEEF);
    wait_idle();
    host_request(1'b0, 19'h00010, 32'h12345678);
    wait_idle();
    chk("host_hs_count", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      chk("host_write_we", hs_log[0], {1'b1, 19'h00010});
      chk("host_read_we", hs_log[1], {1'b0, 19'h00010});
    end
    chk("host_ack_count", hrd_log.size(), 2);
    if (hrd_log.size() == 2) chk("host_read_data", hrd_log[1], 32'hDEADBEEF);

    // both requesters held high: grants must alternate
    ack_mode = 0; clear_logs();
    @(negedge pixel_clk); #1;
    vid_req = 1; vid_addr = 19'h00400; host_req = 1; host_we = 0; host_addr = 19'h00020;
    n = 0;
    while (grant_log.size() < 4 && n < 400) begin
      @(negedge pixel_clk); #1; n++;
    end
    if (n >= 400) timeout_fail("tie_grants");
    vid_req = 0; host_req = 0;
    wait_idle();
    chk("tie_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("tie_grant_order", grant_log[i], (i % 2 == 0) ? 1 : 2);

    // address wrap
    ack_mode = 1; clear_logs();
    vid_request(19'h7FFFE);
    wait_idle();
    chk("wrap_hs_count", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      chk("wrap_addr", hs_log[i], {1'b0, wrap_exp[i]});

    // stall at cnt = 2 for five cycles
    ack_mode = 2; stall_done = 0; stall_active = 0; clear_logs();
    vid_request(19'h00200);
    n = 0;
    while (!stall_active && n < 50) begin
      @(negedge pixel_clk); #2; n++;
    end
    if (n >= 50) timeout_fail("stall_start");
    repeat (5) begin
      @(negedge pixel_clk); #2;
      chk("stall_addr_hold", mem_addr, 19'h00202);
      chk("stall_no_rvalid", vid_rvalid, 0);
    end
    wait_idle();
    chk("stall_rvalid_total", rv_cnt, 4);
    chk("stall_done_count", done_at.size(), 1);

    // reset mid-burst at cnt = 1
    ack_mode = 1; clear_logs();
    vid_request(19'h00300);
    @(negedge pixel_clk); #3;
    chk("rst_pre_addr", mem_addr, 19'h00301);
    pixel_rst = 1'b1; #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_vid_rvalid", vid_rvalid, 0);
    repeat (2) @(negedge pixel_clk);
    #1 pixel_rst = 1'b0;
    chk("rst_no_done", done_at.size(), 0);
    grant_log.delete();
    host_request(1'b0, 19'h00055, 32'h0);
    wait_idle();
    chk("post_rst_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("post_rst_host_first", grant_log[0], 2);

    // randomized traffic
    ack_mode = 0;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 2);
      va   = ($urandom_range(0, 3) == 0) ? AW'(19'h7FFFC + 19'($urandom_range(0, 3))) : AW'($urandom);
      hwe  = $urandom_range(0, 1);
      ha   = AW'($urandom_range(0, 15));
      hd   = $urandom;
      case (kind)
        0: vid_request(va);
        1: host_request(hwe, ha, hd);
        default: fork
          vid_request(va);
          host_request(hwe, ha, hd);
        join
      endcase
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge pixel_clk);
    end

    repeat (3) @(negedge pixel_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
